// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
// Holds the transmitter state encoding and the line-level bit values.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPT,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Ports: clock, reset (async active-low), clear (sync), enable, bit_done (1-cycle pulse).
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign bit_done = enable && (cnt == TERM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the 8-entry FIFO and serialises them as 8N1 UART frames.
// Ports: clock, reset (async active-low), tx_enable, fifo_empty, fifo_wr_active,
//        fifo_data (registered FIFO read data), fifo_rd (pop strobe), tx (line), busy.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic              fifo_empty,
    input  logic              fifo_wr_active,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              bit_done;
    logic              baud_run;
    logic              baud_clr;

    assign fifo_rd  = (state_q == ST_REQ);
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign baud_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);
    assign baud_clr = (state_q == ST_CAPT);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .clear   (baud_clr),
        .enable  (baud_run),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_enable && !fifo_empty) state_d = ST_REQ;
            end
            ST_REQ: begin
                // The FIFO favours writes, so a concurrent write voids the pop.
                if (fifo_wr_active) begin
                    if (fifo_empty) state_d = ST_IDLE;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                shift_d = fifo_data;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (tx_enable && !fifo_empty) state_d = ST_REQ;
                    else state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx never glitches.
    always_comb begin
        tx_d = UART_STOP_BIT;
        if (state_d == ST_START) tx_d = UART_START_BIT;
        else if (state_d == ST_DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule
